// File: rtl/phase_scheduler_pkg.sv
// Shared types and constants for the intersection phase scheduler.
package phase_pkg;

  // Phase encodings, visible on the phase output.
  typedef enum logic [2:0] {
    MAIN_G  = 3'd0,
    MAIN_Y  = 3'd1,
    ALL_RED = 3'd2,
    SIDE_G  = 3'd3,
    SIDE_Y  = 3'd4,
    WALK    = 3'd5,
    RED_RET = 3'd6
  } phase_e;

  // Lamp patterns {R,Y,G}, one-hot.
  localparam logic [2:0] LT_R = 3'b100;
  localparam logic [2:0] LT_Y = 3'b010;
  localparam logic [2:0] LT_G = 3'b001;

  // Interval table indices.
  localparam logic [1:0] SEL_BASE = 2'd0;
  localparam logic [1:0] SEL_EXT  = 2'd1;
  localparam logic [1:0] SEL_YEL  = 2'd2;
  localparam logic [1:0] SEL_WALK = 2'd3;

  // Round-robin pointer values.
  localparam logic RR_SIDE = 1'b0;
  localparam logic RR_WALK = 1'b1;

  // Main-road lamp for a given phase; red whenever main is not moving.
  function automatic logic [2:0] main_lamp(input phase_e p);
    case (p)
      MAIN_G:  main_lamp = LT_G;
      MAIN_Y:  main_lamp = LT_Y;
      default: main_lamp = LT_R;
    endcase
  endfunction

  // Side-street lamp for a given phase.
  function automatic logic [2:0] side_lamp(input phase_e p);
    case (p)
      SIDE_G:  side_lamp = LT_G;
      SIDE_Y:  side_lamp = LT_Y;
      default: side_lamp = LT_R;
    endcase
  endfunction

endpackage

// File: rtl/phase_scheduler_if.sv
// Request, programming and lamp/status bundle of the phase scheduler.
interface phase_scheduler_if #(parameter int CW = 4);
  logic          tick;
  logic          side_req;
  logic          walk_req;
  logic          preempt;
  logic          prog_we;
  logic [1:0]    prog_sel;
  logic [CW-1:0] prog_val;
  logic [2:0]    main_lt;
  logic [2:0]    side_lt;
  logic          walk_on;
  logic [2:0]    phase;
  logic [CW-1:0] remaining;
  logic          side_ack;
  logic          walk_ack;
  logic          prog_ack;

  modport master (
    output tick, side_req, walk_req, preempt, prog_we, prog_sel, prog_val,
    input  main_lt, side_lt, walk_on, phase, remaining, side_ack, walk_ack, prog_ack
  );

  modport slave (
    input  tick, side_req, walk_req, preempt, prog_we, prog_sel, prog_val,
    output main_lt, side_lt, walk_on, phase, remaining, side_ack, walk_ack, prog_ack
  );
endinterface

// File: rtl/phase_scheduler_interval_table.sv
// Programmable 4-entry interval register file with defaults and a
// read port that never returns zero (a zero interval means one tick).
module interval_table
  import phase_pkg::*;
#(
  parameter int CW       = 4,
  parameter int BASE_DEF = 6,
  parameter int EXT_DEF  = 3,
  parameter int YEL_DEF  = 2,
  parameter int WALK_DEF = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [1:0]    wsel,
  input  logic [CW-1:0] wval,
  output logic          ack,
  input  logic [1:0]    rsel,
  output logic [CW-1:0] rval
);

  logic [CW-1:0] tbl_r [4];
  logic          ack_r;
  logic [CW-1:0] raw_s;

  // Table storage: defaults on reset, otherwise take the written entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_r[SEL_BASE] <= CW'(BASE_DEF);
      tbl_r[SEL_EXT]  <= CW'(EXT_DEF);
      tbl_r[SEL_YEL]  <= CW'(YEL_DEF);
      tbl_r[SEL_WALK] <= CW'(WALK_DEF);
    end else if (we) begin
      tbl_r[wsel] <= wval;
    end
  end

  // Write acknowledge, one cycle after each accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r <= 1'b0;
    end else begin
      ack_r <= we;
    end
  end

  // Zero-clamped read of the selected entry.
  always_comb begin
    raw_s = tbl_r[rsel];
    if (raw_s == '0) begin
      rval = CW'(1);
    end else begin
      rval = raw_s;
    end
  end

  assign ack = ack_r;

endmodule

// File: rtl/phase_scheduler.sv
// Intersection phase controller: tick-driven countdown, round-robin
// side/walk arbitration and level-sensitive emergency preempt.
module phase_scheduler
  import phase_pkg::*;
#(
  parameter int BASE_DEF = 6,
  parameter int EXT_DEF  = 3,
  parameter int YEL_DEF  = 2,
  parameter int WALK_DEF = 4,
  parameter int CW       = 4
) (
  input logic          clk,
  input logic          rst,
  phase_scheduler_if.slave bus
);

  phase_e        state_r, next_state_s;
  logic [CW-1:0] remaining_r, remaining_next_s, interval_s, load_val_s;
  logic [1:0]    rd_sel_s;
  logic          side_pend_r, walk_pend_r, rr_r, rr_next_s;
  logic          grant_side_s, grant_walk_s, expire_s;
  logic [2:0]    main_lt_r, side_lt_r;
  logic          walk_on_r, side_ack_r, walk_ack_r, prog_ack_s;

  interval_table #(
    .CW(CW), .BASE_DEF(BASE_DEF), .EXT_DEF(EXT_DEF),
    .YEL_DEF(YEL_DEF), .WALK_DEF(WALK_DEF)
  ) u_table (
    .clk  (clk),
    .rst  (rst),
    .we   (bus.prog_we),
    .wsel (bus.prog_sel),
    .wval (bus.prog_val),
    .ack  (prog_ack_s),
    .rsel (rd_sel_s),
    .rval (interval_s)
  );

  // Next phase, grant decision and round-robin update.
  always_comb begin
    next_state_s = state_r;
    grant_side_s = 1'b0;
    grant_walk_s = 1'b0;
    rr_next_s    = rr_r;
    expire_s     = bus.tick && (remaining_r == CW'(1));
    case (state_r)
      MAIN_G: begin
        if (bus.tick && (remaining_r <= CW'(1)) && (side_pend_r || walk_pend_r) && !bus.preempt) begin
          next_state_s = MAIN_Y;
        end else begin
          next_state_s = MAIN_G;
        end
      end
      MAIN_Y: begin
        if (expire_s) next_state_s = ALL_RED;
        else          next_state_s = MAIN_Y;
      end
      ALL_RED: begin
        if (!expire_s) begin
          next_state_s = ALL_RED;
        end else if (bus.preempt) begin
          next_state_s = RED_RET;
        end else if (side_pend_r && walk_pend_r) begin
          if (rr_r == RR_SIDE) begin
            next_state_s = SIDE_G;
            grant_side_s = 1'b1;
            rr_next_s    = RR_WALK;
          end else begin
            next_state_s = WALK;
            grant_walk_s = 1'b1;
            rr_next_s    = RR_SIDE;
          end
        end else if (side_pend_r) begin
          next_state_s = SIDE_G;
          grant_side_s = 1'b1;
        end else if (walk_pend_r) begin
          next_state_s = WALK;
          grant_walk_s = 1'b1;
        end else begin
          next_state_s = RED_RET;
        end
      end
      SIDE_G: begin
        if (bus.preempt || expire_s) next_state_s = SIDE_Y;
        else                         next_state_s = SIDE_G;
      end
      SIDE_Y: begin
        if (expire_s) next_state_s = RED_RET;
        else          next_state_s = SIDE_Y;
      end
      WALK: begin
        if (bus.preempt || expire_s) next_state_s = RED_RET;
        else                         next_state_s = WALK;
      end
      RED_RET: begin
        if (expire_s) next_state_s = MAIN_G;
        else          next_state_s = RED_RET;
      end
      default: next_state_s = MAIN_G;
    endcase
  end

  // Interval to load for the phase being entered, and the countdown update.
  always_comb begin
    case (next_state_s)
      MAIN_G:  rd_sel_s = SEL_BASE;
      SIDE_G:  rd_sel_s = SEL_EXT;
      WALK:    rd_sel_s = SEL_WALK;
      default: rd_sel_s = SEL_YEL;
    endcase
    case (next_state_s)
      ALL_RED, RED_RET: load_val_s = CW'(1);
      default:          load_val_s = interval_s;
    endcase
    if (next_state_s != state_r) begin
      remaining_next_s = load_val_s;
    end else if (bus.tick && (remaining_r != '0)) begin
      remaining_next_s = remaining_r - CW'(1);
    end else begin
      remaining_next_s = remaining_r;
    end
  end

  // Phase, countdown, request latches and registered lamp/ack outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= MAIN_G;
      remaining_r <= CW'(BASE_DEF);
      side_pend_r <= 1'b0;
      walk_pend_r <= 1'b0;
      rr_r        <= RR_SIDE;
      main_lt_r   <= LT_G;
      side_lt_r   <= LT_R;
      walk_on_r   <= 1'b0;
      side_ack_r  <= 1'b0;
      walk_ack_r  <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      remaining_r <= remaining_next_s;
      side_pend_r <= grant_side_s ? 1'b0 : (side_pend_r | bus.side_req);
      walk_pend_r <= grant_walk_s ? 1'b0 : (walk_pend_r | bus.walk_req);
      rr_r        <= rr_next_s;
      main_lt_r   <= main_lamp(next_state_s);
      side_lt_r   <= side_lamp(next_state_s);
      walk_on_r   <= (next_state_s == WALK);
      side_ack_r  <= grant_side_s;
      walk_ack_r  <= grant_walk_s;
    end
  end

  assign bus.phase     = state_r;
  assign bus.remaining = remaining_r;
  assign bus.main_lt   = main_lt_r;
  assign bus.side_lt   = side_lt_r;
  assign bus.walk_on   = walk_on_r;
  assign bus.side_ack  = side_ack_r;
  assign bus.walk_ack  = walk_ack_r;
  assign bus.prog_ack  = prog_ack_s;

endmodule

// File: tb/tb_phase_scheduler.sv
// Scoreboard bench for phase_scheduler: stimulus pushes expected phase
// entries and write-ack cycles; a negedge monitor pops and compares.
module tb_phase_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phase_scheduler_if #(.CW(4)) bus ();

  phase_scheduler #(
    .BASE_DEF(6), .EXT_DEF(3), .YEL_DEF(2), .WALK_DEF(4), .CW(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [15:0] exp_q [$];
  int          ack_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Expected {phase, main_lt, side_lt, walk_on, remaining, side_ack, walk_ack}.
  function automatic logic [15:0] mk(input logic [2:0] ph, input logic [3:0] rem,
                                     input logic sa, input logic wa);
    logic [2:0] m;
    logic [2:0] s;
    case (ph)
      3'd0:    begin m = 3'b001; s = 3'b100; end
      3'd1:    begin m = 3'b010; s = 3'b100; end
      3'd3:    begin m = 3'b100; s = 3'b001; end
      3'd4:    begin m = 3'b100; s = 3'b010; end
      default: begin m = 3'b100; s = 3'b100; end
    endcase
    return {ph, m, s, (ph == 3'd5), rem, sa, wa};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] ph, input logic [3:0] rem,
                      input logic sa, input logic wa);
    exp_q.push_back(mk(ph, rem, sa, wa));
  endtask

  // Standard served-side and served-walk excursions from MAIN_G.
  task automatic push_side_cycle(input logic [3:0] ext);
    push(3'd1, 4'd2, 1'b0, 1'b0); push(3'd2, 4'd1, 1'b0, 1'b0);
    push(3'd3, ext, 1'b1, 1'b0);  push(3'd4, 4'd2, 1'b0, 1'b0);
    push(3'd6, 4'd1, 1'b0, 1'b0); push(3'd0, 4'd6, 1'b0, 1'b0);
  endtask

  task automatic push_walk_cycle(input logic [3:0] wlen);
    push(3'd1, 4'd2, 1'b0, 1'b0); push(3'd2, 4'd1, 1'b0, 1'b0);
    push(3'd5, wlen, 1'b0, 1'b1); push(3'd6, 4'd1, 1'b0, 1'b0);
    push(3'd0, 4'd6, 1'b0, 1'b0);
  endtask

  task automatic do_tick();
    @(posedge clk); #1 bus.tick = 1'b1;
    @(posedge clk); #1 bus.tick = 1'b0;
  endtask

  task automatic ticks(input int n, input logic [2:0] ph);
    repeat (n) do_tick();
    chk("phase_after_ticks", {29'd0, bus.phase}, {29'd0, ph});
  endtask

  task automatic pulse_side();
    @(posedge clk); #1 bus.side_req = 1'b1;
    @(posedge clk); #1 bus.side_req = 1'b0;
  endtask

  task automatic pulse_walk();
    @(posedge clk); #1 bus.walk_req = 1'b1;
    @(posedge clk); #1 bus.walk_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_phase",    {29'd0, bus.phase},   32'd0);
    chk("rst_main_lt",  {29'd0, bus.main_lt}, 32'd1);
    chk("rst_side_lt",  {29'd0, bus.side_lt}, 32'd4);
    chk("rst_walk_on",  {31'd0, bus.walk_on}, 32'd0);
    chk("rst_remaining",{28'd0, bus.remaining}, 32'd6);
    chk("rst_acks", {29'd0, bus.side_ack, bus.walk_ack, bus.prog_ack}, 32'd0);
  endtask

  // Monitor: phase transitions and write acks are checked against the queues.
  initial begin
    logic [2:0]  prev;
    logic [15:0] act;
    logic [15:0] e;
    int          ec;
    prev = 3'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = bus.phase;
      end else begin
        act = {bus.phase, bus.main_lt, bus.side_lt, bus.walk_on, bus.remaining,
               bus.side_ack, bus.walk_ack};
        if (bus.phase !== prev) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_transition actual=%h expected=none", act);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
              failures++;
              $display("FAIL phase_entry actual=%h expected=%h (t=%0t)", act, e, $time);
            end
          end
          prev = bus.phase;
        end else if (bus.side_ack || bus.walk_ack) begin
          checks++;
          failures++;
          $display("FAIL stray_ack actual=%b%b expected=00", bus.side_ack, bus.walk_ack);
        end
        if (bus.prog_ack) begin
          checks++;
          if (ack_q.size() == 0) begin
            failures++;
            $display("FAIL prog_ack actual=cycle %0d expected=none", cyc);
          end else begin
            ec = ack_q.pop_front();
            if (cyc != ec) begin
              failures++;
              $display("FAIL prog_ack_cycle actual=%0d expected=%0d", cyc, ec);
            end
          end
        end
      end
    end
  end

  initial begin
    bus.tick = 1'b0; bus.side_req = 1'b0; bus.walk_req = 1'b0; bus.preempt = 1'b0;
    bus.prog_we = 1'b0; bus.prog_sel = 2'd0; bus.prog_val = 4'd0;
    do_reset();
    chk_reset_state();

    // Idle: countdown 6..0 then holds at 0.
    for (int k = 1; k <= 20; k++) begin
      do_tick();
      chk("idle_remaining", {28'd0, bus.remaining}, (k < 6) ? 32'(6 - k) : 32'd0);
    end
    chk("idle_phase", {29'd0, bus.phase}, 32'd0);

    // Single side request served with full default timings.
    do_reset();
    push_side_cycle(4'd3);
    pulse_side();
    ticks(5, 3'd0); ticks(1, 3'd1); ticks(1, 3'd1); ticks(1, 3'd2);
    ticks(1, 3'd3); ticks(2, 3'd3); ticks(1, 3'd4); ticks(1, 3'd4);
    ticks(1, 3'd6); ticks(1, 3'd0);

    // Both requests together: side first (rr at side), then walk.
    push_side_cycle(4'd3);
    push_walk_cycle(4'd4);
    @(posedge clk); #1 bus.side_req = 1'b1; bus.walk_req = 1'b1;
    @(posedge clk); #1 bus.side_req = 1'b0; bus.walk_req = 1'b0;
    ticks(6, 3'd1); ticks(2, 3'd2); ticks(1, 3'd3); ticks(3, 3'd4);
    ticks(2, 3'd6); ticks(1, 3'd0);
    ticks(6, 3'd1); ticks(2, 3'd2); ticks(1, 3'd5); ticks(4, 3'd6); ticks(1, 3'd0);
    ticks(6, 3'd0);
    chk("idle_after_both", {28'd0, bus.remaining}, 32'd0);

    // Preempt cuts SIDE_G short and holds MAIN_G with walk pending.
    push(3'd1, 4'd2, 1'b0, 1'b0); push(3'd2, 4'd1, 1'b0, 1'b0);
    push(3'd3, 4'd3, 1'b1, 1'b0); push(3'd4, 4'd2, 1'b0, 1'b0);
    push(3'd6, 4'd1, 1'b0, 1'b0); push(3'd0, 4'd6, 1'b0, 1'b0);
    push_walk_cycle(4'd4);
    pulse_side();
    ticks(1, 3'd1); ticks(2, 3'd2); ticks(1, 3'd3);
    pulse_walk();
    ticks(1, 3'd3);
    chk("sideg_rem_before_preempt", {28'd0, bus.remaining}, 32'd2);
    bus.preempt = 1'b1;
    @(posedge clk); #1;
    chk("preempt_to_side_y", {29'd0, bus.phase}, 32'd4);
    ticks(2, 3'd6); ticks(1, 3'd0); ticks(10, 3'd0);
    chk("preempt_hold_rem", {28'd0, bus.remaining}, 32'd0);
    bus.preempt = 1'b0;
    ticks(1, 3'd1); ticks(2, 3'd2); ticks(1, 3'd5); ticks(4, 3'd6); ticks(1, 3'd0);

    // Reprogram ext=0 and walk=2 mid SIDE_G; current SIDE_G keeps 3 ticks.
    push_side_cycle(4'd3);
    push_side_cycle(4'd1);
    pulse_side();
    ticks(6, 3'd1); ticks(2, 3'd2); ticks(1, 3'd3);
    bus.prog_we = 1'b1; bus.prog_sel = 2'd1; bus.prog_val = 4'd0;
    ack_q.push_back(cyc + 1);
    @(posedge clk); #1 bus.prog_sel = 2'd3; bus.prog_val = 4'd2;
    ack_q.push_back(cyc + 1);
    @(posedge clk); #1 bus.prog_we = 1'b0;
    chk("sideg_rem_after_prog", {28'd0, bus.remaining}, 32'd3);
    ticks(2, 3'd3); ticks(1, 3'd4); ticks(2, 3'd6); ticks(1, 3'd0);
    pulse_side();
    ticks(6, 3'd1); ticks(2, 3'd2); ticks(1, 3'd3); ticks(1, 3'd4);
    ticks(2, 3'd6); ticks(1, 3'd0);

    // Reset mid-WALK with a side request pending.
    push(3'd1, 4'd2, 1'b0, 1'b0); push(3'd2, 4'd1, 1'b0, 1'b0);
    push(3'd5, 4'd2, 1'b0, 1'b1);
    pulse_walk();
    ticks(6, 3'd1); ticks(2, 3'd2); ticks(1, 3'd5); ticks(1, 3'd5);
    chk("walk_rem_programmed", {28'd0, bus.remaining}, 32'd1);
    pulse_side();
    do_reset();
    chk_reset_state();
    ticks(8, 3'd0);
    push_walk_cycle(4'd4);
    pulse_walk();
    ticks(1, 3'd1); ticks(2, 3'd2); ticks(1, 3'd5); ticks(4, 3'd6); ticks(1, 3'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_scheduler.md
Name: phase_scheduler

Overview:
- Intersection phase controller that shares green time between the main road, a side-street sensor requester and a pedestrian walk requester.
- Owns a programmable interval table and a tick-driven countdown.
- Arbitrates pending side and walk requests round-robin, with emergency preempt returning to main green via a safe path.
- Sits between the input synchroniser/1 Hz divider and the lamp/seven-segment drivers.

Parameters:
- BASE_DEF, 6, default main-green minimum (ticks)
- EXT_DEF, 3, default side-green duration
- YEL_DEF, 2, default yellow duration
- WALK_DEF, 4, default walk duration
- CW, 4, interval/counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- tick  in  1  one-cycle 1 Hz enable
- side_req  in  1  synchronised side sensor; level or pulse
- walk_req  in  1  synchronised walk button; level or pulse
- preempt  in  1  emergency preempt, level
- prog_we  in  1  interval write strobe
- prog_sel  in  2  0=base 1=ext 2=yellow 3=walk
- prog_val  in  CW  new interval
- main_lt  out  3  {R,Y,G} one-hot
- side_lt  out  3  {R,Y,G} one-hot
- walk_on  out  1  pedestrian walk lamp
- phase  out  3  state encoding
- remaining  out  CW  ticks left in phase
- side_ack  out  1  one-cycle grant pulse
- walk_ack  out  1  one-cycle grant pulse
- prog_ack  out  1  one-cycle write acknowledge

Behaviour:
- States and encodings: MAIN_G=0, MAIN_Y=1, ALL_RED=2, SIDE_G=3, SIDE_Y=4, WALK=5, RED_RET=6.
- Lamps:
  - MAIN_G: main G, side R.
  - MAIN_Y: main Y, side R.
  - SIDE_G: main R, side G.
  - SIDE_Y: main R, side Y.
  - ALL_RED, WALK, RED_RET: both R.
  - walk_on=1 only in WALK.
- Phase load: on entry to each state, remaining loads that phase's interval.
  - MAIN_G: base. MAIN_Y and SIDE_Y: yellow. SIDE_G: ext. WALK: walk.
  - ALL_RED and RED_RET: fixed 1.
  - A stored interval of 0 is loaded as 1.
- Countdown: decrement on tick only. A timed phase leaves on the clk edge where tick=1 and remaining==1, so a phase lasts N ticks.
- MAIN_G:
  - remaining decrements and saturates at 0.
  - Leaves to MAIN_Y on a tick with remaining<=1, (side_pend|walk_pend) and !preempt.
  - Otherwise holds indefinitely.
- Other transitions:
  - MAIN_Y -> ALL_RED.
  - ALL_RED -> grant target.
  - SIDE_G -> SIDE_Y -> RED_RET.
  - WALK -> RED_RET.
  - RED_RET -> MAIN_G.
- Request latches:
  - side_pend and walk_pend set on any cycle the corresponding req=1.
  - Each clears on the cycle its grant is issued.
  - If set and clear coincide, clear wins; the request is being served.
- Grant (ALL_RED expiry):
  - Only one pending: grant it.
  - Both pending: grant the requester indicated by rr_ptr; rr_ptr then points to the other.
  - rr_ptr resets to side.
  - Neither pending (e.g. withdrawn), or preempt=1: go to RED_RET with no grant.
- side_ack/walk_ack: high for exactly the cycle the FSM registers entry into SIDE_G/WALK.
- Preempt, level-sensitive, evaluated every clk:
  - In SIDE_G: next cycle -> SIDE_Y.
  - In WALK: next cycle -> RED_RET.
  - MAIN_Y, SIDE_Y, ALL_RED, RED_RET: complete normally, no yellow shortening.
  - MAIN_G: held while preempt=1.
  - Pending latches are retained through preempt.
- Reprogram:
  - prog_we writes prog_val into table[prog_sel] at the clk edge.
  - prog_ack=1 on the following cycle.
  - The current countdown is unaffected; the new value applies at the next load of that phase.
  - Back-to-back writes are all accepted.
- tick and prog_we in the same cycle are independent.
- Reset (rst=1 at clk edge) overrides everything. Next-cycle values:
  - phase=MAIN_G, main_lt=3'b001, side_lt=3'b100, walk_on=0, remaining=BASE_DEF.
  - Table = defaults, pend latches 0, rr_ptr=side, all acks 0.
- Reset mid-phase (e.g. WALK) returns to MAIN_G immediately. This is accepted, because red is shown on all non-main approaches.

Decomposition:
- Shared package phase_pkg: state enum with the encodings above, lamp constants (LT_R=3'b100, LT_Y=3'b010, LT_G=3'b001), prog_sel codes.
- One natural sub-module: interval_table. It holds the 4xCW register file with defaults, write port, ack and zero-clamped read by index.
- Countdown, arbiter and FSM stay in phase_scheduler.

Test Plan:
- Reset, then 20 ticks with no requests -> phase=0, main_lt=001, side_lt=100, remaining counts 6..0, then holds 0.
- side_req pulse at t0 -> main G expires after tick 6, MAIN_Y 2 ticks, ALL_RED 1, SIDE_G 3 with side_ack 1 cycle, SIDE_Y 2, RED_RET 1, back to MAIN_G.
- side_req and walk_req both pulsed -> first cycle grants side; second cycle grants walk (walk_on for 4 ticks), then idle in MAIN_G.
- preempt=1 during SIDE_G with remaining=2 -> SIDE_Y next clk; with preempt held, MAIN_G does not leave despite walk_pend=1. On release, walk is served.
- prog_we sel=1 val=0 during SIDE_G -> prog_ack next cycle, current SIDE_G completes 3 ticks, next SIDE_G lasts 1 tick.
- rst asserted mid-WALK -> next cycle phase=0, walk_on=0, remaining=6, pend latches cleared, table back to defaults.
